// File: rtl/mem_master.sv
// Memory bus initiator: arbitrates core fetch/data requests and sequences the memory strobes.
// Optional MEM_MASTER_ADDR_CHECK_EN: requests with addr[15:8] != 0 complete at once with err=1.
`timescale 1ns/1ps
module mem_master (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_req,
   input  logic [15:0] fetch_addr,
   output logic        fetch_ack,
   output logic [15:0] fetch_data,
   input  logic        data_req,
   input  logic        data_we,
   input  logic [15:0] data_addr,
   input  logic [15:0] data_wdata,
   output logic        data_ack,
   output logic [15:0] data_rdata,
   output logic        err,
   output logic        i_read,
   output logic        i_push,
   output logic        d_read,
   output logic        d_write,
   output logic        d_push,
   output logic [15:0] i_addr,
   output logic [15:0] d_addr,
   inout  wire  [15:0] d_bus
);

   typedef enum logic [2:0] {IDLE, IRD, IPUSH, DRD, DPUSH, WR, DONE} state_t;

   state_t      state;
   logic        last_data;
   logic        cur_data;
   logic [15:0] wdata_q;
   logic        sel_data;
   logic        out_of_range;

   // Data wins unless a fetch is also pending and data was served last.
   always_comb begin
      sel_data = data_req && (!fetch_req || !last_data);
   end

`ifdef MEM_MASTER_ADDR_CHECK_EN
   logic err_q;

   always_comb begin
      out_of_range = sel_data ? (|data_addr[15:8]) : (|fetch_addr[15:8]);
   end

   assign err = (state == DONE) && err_q;
`else
   assign out_of_range = 1'b0;
   assign err          = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         last_data  <= 1'b0;
         cur_data   <= 1'b0;
         wdata_q    <= '0;
         i_addr     <= '0;
         d_addr     <= '0;
         fetch_data <= '0;
         data_rdata <= '0;
`ifdef MEM_MASTER_ADDR_CHECK_EN
         err_q      <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (data_req || fetch_req) begin
                  last_data <= sel_data;
                  cur_data  <= sel_data;
`ifdef MEM_MASTER_ADDR_CHECK_EN
                  err_q     <= out_of_range;
`endif
                  if (out_of_range) begin
                     // Rejected request bypasses memory; addresses keep their old value.
                     state <= DONE;
                     if (sel_data && !data_we) data_rdata <= '0;
                     if (!sel_data)            fetch_data <= '0;
                  end else if (sel_data) begin
                     d_addr  <= data_addr;
                     wdata_q <= data_wdata;
                     state   <= data_we ? WR : DRD;
                  end else begin
                     i_addr <= fetch_addr;
                     state  <= IRD;
                  end
               end
            end
            IRD:   state <= IPUSH;
            IPUSH: begin
               fetch_data <= d_bus;
               state      <= DONE;
            end
            DRD:   state <= DPUSH;
            DPUSH: begin
               data_rdata <= d_bus;
               state      <= DONE;
            end
            WR:    state <= DONE;
            DONE:  state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      i_read    = (state == IRD);
      i_push    = (state == IPUSH);
      d_read    = (state == DRD);
      d_push    = (state == DPUSH);
      d_write   = (state == WR);
      fetch_ack = (state == DONE) && !cur_data;
      data_ack  = (state == DONE) && cur_data;
   end

   assign d_bus = (state == WR) ? wdata_q : 'z;

endmodule
